param_queue_mc: RTL and testbench
=================================

Name: param_queue_mc

Overview:
- Parameterised synchronous FIFO queue; successor to the team's basic single-pointer queue.
- Adds a fill-level count and programmable almost-full/almost-empty thresholds.
- Adds a registered read-data valid strobe, a synchronous flush, and sticky overflow/underflow error flags.
- Allows simultaneous enqueue/dequeue, including at full.
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- WIDTH, 8: data width in bits; must be >= 1.
- DEPTH, 16: number of entries; must be >= 2; need not be a power of two.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.
- CW, $clog2(DEPTH+1): count width. Derived; never overridden.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- clear  in  1  synchronous flush. Same effect as reset on pointers, count and flags. Does not clear sticky errors.
- data_in  in  WIDTH  enqueue data.
- enqueue  in  1  write request.
- dequeue  in  1  read request.
- data_out  out  WIDTH  registered read data.
- out_valid  out  1  one-cycle strobe: data_out holds newly dequeued data.
- count  out  CW  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: an enqueue was rejected.
- underflow  out  1  sticky: a dequeue was rejected.

Behaviour:
- Reset (rst==0 at posedge):
  - Pointers and count go to 0. data_out = 0.
  - out_valid = 0, full = 0, empty = 1, almost_full = 0, almost_empty = 1.
  - overflow = 0, underflow = 0.
  - Storage array is not cleared.
  - Reset mid-operation discards all contents; no pending output.
- Reset has priority over clear. clear has priority over enqueue/dequeue.
- clear: pointers and count go to 0, out_valid = 0, data_out holds. Requests in that cycle are ignored and are not flagged as errors.
- Acceptance:
  - deq_ok = dequeue && count != 0.
  - enq_ok = enqueue && (count != DEPTH || deq_ok).
  - Write-through at full is therefore permitted when a dequeue is accepted in the same cycle.
  - At empty, a simultaneous enqueue/dequeue accepts the enqueue only. No bypass; underflow is set.
- Pointers:
  - Write pointer and read pointer run 0..DEPTH-1 and wrap to 0 after DEPTH-1 (explicit compare, not modulo-2^n).
  - enq_ok writes data_in at the write pointer, then advances it.
  - deq_ok loads data_out from the read pointer, then advances it.
- Count update:
  - +1 on enq_ok only; -1 on deq_ok only; unchanged on both or neither.
- Status flags:
  - full, empty, almost_full and almost_empty are registered.
  - They are computed from the next count, so they are valid in the same cycle as count.
- Read latency: data_out and out_valid update at the posedge of an accepted dequeue and are visible the following cycle.
  - out_valid = deq_ok delayed one cycle.
  - data_out holds its value when no dequeue is accepted.
- Errors:
  - overflow sets on enqueue && !enq_ok.
  - underflow sets on dequeue && !deq_ok.
  - Both clear only on reset.
- Ordering: strict FIFO order is preserved across wrap-around.

Optional Feature:
- Macro: PARAM_QUEUE_PEAK_EN.
- When defined:
  - Adds output peak (CW bits): the maximum count observed since the last reset or clear.
  - Adds input peak_clr (1 bit): peak_clr=1 loads peak with the current count.
  - peak updates registered each cycle: peak = max(peak, next count).
  - peak = 0 on reset and clear.
- When undefined: neither port exists; no peak logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset then idle, defaults: count=0, empty=1, almost_empty=1, full=0, out_valid=0, data_out=0, overflow=0, underflow=0.
- Fill and drain: enqueue 0x01..0x10 into DEPTH=16.
  - After fill: full=1, count=16, almost_full=1 from count=14.
  - Then 16 dequeues: data_out sequence 0x01..0x10, each one cycle after request with out_valid=1; empty=1 at the end.
- Wrap-around, DEPTH=5:
  - Enqueue 3 items, dequeue 3, enqueue 5 items (0xA0..0xA4).
  - Then dequeue 5: order 0xA0..0xA4; count returns to 0.
- Simultaneous operations:
  - At full, enqueue 0x55 with dequeue: count stays 16, overflow=0; 0x55 emerges last.
  - At empty, enqueue with dequeue: count=1, underflow=1, out_valid=0.
- Error and flush:
  - Enqueue at full without dequeue: overflow=1, count unchanged.
  - Then clear: count=0, empty=1, overflow remains 1.
  - Then rst=0: overflow=0.
- Optional feature (PARAM_QUEUE_PEAK_EN): enqueue 7, dequeue 4, enqueue 2 -> peak=7. Then peak_clr -> peak=5.

Source files
------------

// File: rtl/param_queue_mc_if.sv
// ----------------------------------------------------------------------------
// param_queue_mc_if
//   Handshake/data bundle between a producer/consumer pair and param_queue_mc.
//   master : the block driving requests (producer/consumer side, testbench)
//   slave  : the queue itself
//   Signals:
//     clear        flush request (master -> slave)
//     data_in      enqueue data  (master -> slave)
//     enqueue      write request (master -> slave)
//     dequeue      read request  (master -> slave)
//     data_out     registered read data        (slave -> master)
//     out_valid    one-cycle read-data strobe  (slave -> master)
//     count        occupancy 0..DEPTH          (slave -> master)
//     full/empty/almost_full/almost_empty      registered status
//     overflow/underflow                       sticky error flags
//   Optional (PARAM_QUEUE_PEAK_EN):
//     peak_clr     reload peak with the current count (master -> slave)
//     peak         highest count seen since reset/clear (slave -> master)
// ----------------------------------------------------------------------------
interface param_queue_mc_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             clear;
   logic [WIDTH-1:0] data_in;
   logic             enqueue;
   logic             dequeue;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;
`ifdef PARAM_QUEUE_PEAK_EN
   logic             peak_clr;
   logic [CW-1:0]    peak;

   modport master (
      output clear, data_in, enqueue, dequeue, peak_clr,
      input  data_out, out_valid, count, full, empty, almost_full,
             almost_empty, overflow, underflow, peak
   );
   modport slave (
      input  clear, data_in, enqueue, dequeue, peak_clr,
      output data_out, out_valid, count, full, empty, almost_full,
             almost_empty, overflow, underflow, peak
   );
`else
   modport master (
      output clear, data_in, enqueue, dequeue,
      input  data_out, out_valid, count, full, empty, almost_full,
             almost_empty, overflow, underflow
   );
   modport slave (
      input  clear, data_in, enqueue, dequeue,
      output data_out, out_valid, count, full, empty, almost_full,
             almost_empty, overflow, underflow
   );
`endif
endinterface

// File: rtl/param_queue_mc.sv
// ----------------------------------------------------------------------------
// param_queue_mc
//   Parameterised single-clock FIFO with occupancy count, almost-full/empty
//   thresholds, registered read data with a valid strobe, synchronous flush
//   and sticky overflow/underflow flags. Enqueue and dequeue may be accepted
//   in the same cycle, including at full (write-through).
//   Ports:
//     clk  posedge clock
//     rst  synchronous active-low reset
//     q    param_queue_mc_if.slave (requests in, data/status out)
//   Optional feature macro: PARAM_QUEUE_PEAK_EN adds q.peak / q.peak_clr,
//   a high-water mark of the occupancy.
// ----------------------------------------------------------------------------
module param_queue_mc #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input logic            clk,
   input logic            rst,
   param_queue_mc_if.slave q
);
   localparam int            CW       = $clog2(DEPTH + 1);
   localparam int            PW       = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q;
   logic             vld_q, full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
   logic             deq_ok, enq_ok, wr_en, rd_en, ovf_set, unf_set;

   always_comb begin
      deq_ok  = q.dequeue && (count_q != '0);
      // a full queue still accepts a write when a read frees a slot this cycle
      enq_ok  = q.enqueue && ((count_q != DEPTH_C) || deq_ok);
      // clear swallows requests without flagging them
      wr_en   = enq_ok && !q.clear && rst;
      rd_en   = deq_ok && !q.clear;
      ovf_set = q.enqueue && !enq_ok && !q.clear;
      unf_set = q.dequeue && !deq_ok && !q.clear;

      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (q.clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         // explicit wrap so DEPTH need not be a power of two
         if (enq_ok) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
         if (deq_ok) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
         case ({enq_ok, deq_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= q.data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         vld_q   <= rd_en;
         if (rd_en) dout_q <= mem_q[rptr_q];
         // flags follow the next count so they line up with count
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == '0);
         af_q    <= (count_d >= AF_C);
         ae_q    <= (count_d <= AE_C);
         if (ovf_set) ovf_q <= 1'b1;
         if (unf_set) unf_q <= 1'b1;
      end
   end

`ifdef PARAM_QUEUE_PEAK_EN
   logic [CW-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (q.clear)             peak_d = '0;
      else if (q.peak_clr)     peak_d = count_d;
      else if (count_d > peak_q) peak_d = count_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) peak_q <= '0;
      else      peak_q <= peak_d;
   end

   assign q.peak = peak_q;
`endif

   assign q.data_out     = dout_q;
   assign q.out_valid    = vld_q;
   assign q.count        = count_q;
   assign q.full         = full_q;
   assign q.empty        = empty_q;
   assign q.almost_full  = af_q;
   assign q.almost_empty = ae_q;
   assign q.overflow     = ovf_q;
   assign q.underflow    = unf_q;
endmodule

// File: tb/tb_param_queue_mc.sv
// ----------------------------------------------------------------------------
// tb_param_queue_mc
//   Drives a 16-deep and a 5-deep queue with identical stimulus and compares
//   every output after every clock against a queue-based reference model.
//   Optional feature macro: PARAM_QUEUE_PEAK_EN (peak output also checked).
// ----------------------------------------------------------------------------
module tb_param_queue_mc;
   typedef logic [7:0] q_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, deq = 1'b0, clr = 1'b0, pclr = 1'b0;
   logic [7:0] din = '0;

   int n_vec = 0;
   int n_err = 0;

   param_queue_mc_if #(.WIDTH(8), .DEPTH(16)) if16 ();
   param_queue_mc_if #(.WIDTH(8), .DEPTH(5))  if5 ();

   assign if16.clear = clr;  assign if16.enqueue = en;
   assign if16.dequeue = deq; assign if16.data_in = din;
   assign if5.clear = clr;   assign if5.enqueue = en;
   assign if5.dequeue = deq;  assign if5.data_in = din;
`ifdef PARAM_QUEUE_PEAK_EN
   assign if16.peak_clr = pclr;
   assign if5.peak_clr  = pclr;
`endif

   param_queue_mc #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2))
      u_dut16 (.clk(clk), .rst(rst), .q(if16));
   param_queue_mc #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1))
      u_dut5 (.clk(clk), .rst(rst), .q(if5));

   always #5 clk = ~clk;

   // reference model state
   q_t         mq16, mq5;
   logic [7:0] md16 = '0, md5 = '0;
   bit         mv16, mv5, mo16, mo5, mu16, mu5;
   int         mp16, mp5;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic mstep(input int depth, inout q_t mq, inout logic [7:0] dout,
                        inout bit vld, inout bit ovf, inout bit unf, inout int pk);
      int  c;
      bit  dk, ek;
      if (!rst) begin
         mq.delete(); dout = '0; vld = 0; ovf = 0; unf = 0; pk = 0;
         return;
      end
      if (clr) begin
         mq.delete(); vld = 0; pk = 0;
         return;
      end
      c  = mq.size();
      dk = deq && (c > 0);
      ek = en && ((c < depth) || dk);
      if (deq && !dk) unf = 1;
      if (en && !ek)  ovf = 1;
      vld = dk;
      if (dk) dout = mq.pop_front();
      if (ek) mq.push_back(din);
      if (pclr) pk = mq.size();
      else if (mq.size() > pk) pk = mq.size();
   endtask

   task automatic check_dut(input string nm, input int depth, input int afl, input int ael,
                            input q_t mq, input logic [7:0] m_dout, input bit m_vld,
                            input bit m_ovf, input bit m_unf, input int m_pk,
                            input logic [31:0] o_cnt, input logic [31:0] o_full,
                            input logic [31:0] o_empty, input logic [31:0] o_af,
                            input logic [31:0] o_ae, input logic [31:0] o_dout,
                            input logic [31:0] o_vld, input logic [31:0] o_ovf,
                            input logic [31:0] o_unf, input logic [31:0] o_pk);
      int c;
      c = mq.size();
      chk({nm, ".count"},     o_cnt,   c);
      chk({nm, ".full"},      o_full,  32'(c == depth));
      chk({nm, ".empty"},     o_empty, 32'(c == 0));
      chk({nm, ".a_full"},    o_af,    32'(c >= afl));
      chk({nm, ".a_empty"},   o_ae,    32'(c <= ael));
      chk({nm, ".data_out"},  o_dout,  32'(m_dout));
      chk({nm, ".out_valid"}, o_vld,   32'(m_vld));
      chk({nm, ".overflow"},  o_ovf,   32'(m_ovf));
      chk({nm, ".underflow"}, o_unf,   32'(m_unf));
`ifdef PARAM_QUEUE_PEAK_EN
      chk({nm, ".peak"},      o_pk,    m_pk);
`endif
   endtask

   task automatic check_all();
      logic [31:0] pk16, pk5;
`ifdef PARAM_QUEUE_PEAK_EN
      pk16 = 32'(if16.peak); pk5 = 32'(if5.peak);
`else
      pk16 = '0; pk5 = '0;
`endif
      check_dut("d16", 16, 14, 2, mq16, md16, mv16, mo16, mu16, mp16,
                32'(if16.count), 32'(if16.full), 32'(if16.empty), 32'(if16.almost_full),
                32'(if16.almost_empty), 32'(if16.data_out), 32'(if16.out_valid),
                32'(if16.overflow), 32'(if16.underflow), pk16);
      check_dut("d5", 5, 3, 1, mq5, md5, mv5, mo5, mu5, mp5,
                32'(if5.count), 32'(if5.full), 32'(if5.empty), 32'(if5.almost_full),
                32'(if5.almost_empty), 32'(if5.data_out), 32'(if5.out_valid),
                32'(if5.overflow), 32'(if5.underflow), pk5);
   endtask

   // one clock: advance models on the edge, compare 1ns later
   task automatic cyc();
      @(posedge clk);
      mstep(16, mq16, md16, mv16, mo16, mu16, mp16);
      mstep(5,  mq5,  md5,  mv5,  mo5,  mu5,  mp5);
      #1;
      check_all();
   endtask

   task automatic drv(input bit e, input bit d, input logic [7:0] x);
      en = e; deq = d; din = x; clr = 0; pclr = 0;
   endtask

   task automatic do_reset();
      drv(0, 0, 8'h00);
      rst = 0; cyc(); cyc();
      rst = 1;
   endtask

   initial begin
      // reset defaults
      do_reset();
      drv(0, 0, 8'h00); cyc();
      chk("rst.count", 32'(if16.count), 0);
      chk("rst.empty", 32'(if16.empty), 1);
      chk("rst.data",  32'(if16.data_out), 0);

      // fill and drain, almost_full from count 14
      for (int i = 0; i < 16; i++) begin
         drv(1, 0, 8'(i + 1)); cyc();
         if (i == 12) chk("fill.af13", 32'(if16.almost_full), 0);
         if (i == 13) chk("fill.af14", 32'(if16.almost_full), 1);
      end
      chk("fill.full",  32'(if16.full), 1);
      chk("fill.count", 32'(if16.count), 16);
      for (int i = 0; i < 16; i++) begin
         drv(0, 1, 8'h00); cyc();
         chk("drain.vld",  32'(if16.out_valid), 1);
         chk("drain.data", 32'(if16.data_out), 32'(i + 1));
      end
      drv(0, 0, 8'h00); cyc();
      chk("drain.empty", 32'(if16.empty), 1);

      // wrap-around on the 5-deep queue
      do_reset();
      for (int i = 0; i < 3; i++) begin drv(1, 0, 8'(8'h10 + i)); cyc(); end
      for (int i = 0; i < 3; i++) begin drv(0, 1, 8'h00); cyc(); end
      for (int i = 0; i < 5; i++) begin drv(1, 0, 8'(8'hA0 + i)); cyc(); end
      for (int i = 0; i < 5; i++) begin
         drv(0, 1, 8'h00); cyc();
         chk("wrap.data", 32'(if5.data_out), 32'(8'hA0 + i));
      end
      chk("wrap.count", 32'(if5.count), 0);

      // simultaneous at full, then at empty
      do_reset();
      for (int i = 0; i < 16; i++) begin drv(1, 0, 8'(8'h30 + i)); cyc(); end
      drv(1, 1, 8'h55); cyc();
      chk("wt.count", 32'(if16.count), 16);
      chk("wt.ovf",   32'(if16.overflow), 0);
      for (int i = 0; i < 16; i++) begin drv(0, 1, 8'h00); cyc(); end
      chk("wt.last", 32'(if16.data_out), 32'h55);
      drv(1, 1, 8'h77); cyc();
      chk("emp.count", 32'(if16.count), 1);
      chk("emp.unf",   32'(if16.underflow), 1);
      chk("emp.vld",   32'(if16.out_valid), 0);

      // overflow, clear keeps it, reset drops it
      do_reset();
      for (int i = 0; i < 16; i++) begin drv(1, 0, 8'(i)); cyc(); end
      drv(1, 0, 8'hEE); cyc();
      chk("err.ovf",   32'(if16.overflow), 1);
      chk("err.count", 32'(if16.count), 16);
      drv(1, 1, 8'h00); clr = 1; cyc();
      chk("clr.count", 32'(if16.count), 0);
      chk("clr.empty", 32'(if16.empty), 1);
      chk("clr.ovf",   32'(if16.overflow), 1);
      drv(0, 0, 8'h00); rst = 0; cyc(); rst = 1;
      chk("rst.ovf",   32'(if16.overflow), 0);

      // high-water mark
      do_reset();
      for (int i = 0; i < 7; i++) begin drv(1, 0, 8'(i)); cyc(); end
      for (int i = 0; i < 4; i++) begin drv(0, 1, 8'h00); cyc(); end
      for (int i = 0; i < 2; i++) begin drv(1, 0, 8'(i)); cyc(); end
      drv(0, 0, 8'h00); cyc();
`ifdef PARAM_QUEUE_PEAK_EN
      chk("peak.max", 32'(if16.peak), 7);
`endif
      pclr = 1; cyc(); pclr = 0;
`ifdef PARAM_QUEUE_PEAK_EN
      chk("peak.clr", 32'(if16.peak), 5);
`endif

      // random traffic with drifting enqueue/dequeue bias
      do_reset();
      for (int ph = 0; ph < 4; ph++) begin
         int pe, pd;
         pe = (ph % 2 == 0) ? 75 : 30;
         pd = (ph % 2 == 0) ? 30 : 75;
         for (int i = 0; i < 500; i++) begin
            en   = ($urandom_range(0, 99) < pe);
            deq  = ($urandom_range(0, 99) < pd);
            din  = 8'($urandom);
            clr  = ($urandom_range(0, 63) == 0);
            pclr = ($urandom_range(0, 31) == 0);
            rst  = ($urandom_range(0, 255) != 0);
            cyc();
         end
      end
      rst = 1;
      drv(0, 0, 8'h00); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
